// File: rtl/fir_filter_gd_pipe_chain.sv
// Elastic DEPTH-stage register chain carrying FIR sample, coefficient and overwrite flag.
// Build option FIR_PIPE_BUBBLE_COLLAPSE_EN: per-stage ready so bubbles fill while the output stalls.
module fir_filter_gd_pipe_chain #(
    parameter int DATA_WIDTH  = 32,
    parameter int COEFF_WIDTH = 32,
    parameter int DEPTH       = 4,
    localparam int OCC_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  fir_input_in,
    input  logic [COEFF_WIDTH-1:0] coeff_data_in,
    input  logic                   overwrite_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  fir_input_out,
    output logic [COEFF_WIDTH-1:0] coeff_data_out,
    output logic                   overwrite_out,
    output logic [OCC_WIDTH-1:0]   occupancy
);

    logic [DEPTH-1:0]       v_r;
    logic [DEPTH-1:0]       ow_r;
    logic [DATA_WIDTH-1:0]  data_r  [DEPTH];
    logic [COEFF_WIDTH-1:0] coeff_r [DEPTH];
    logic [OCC_WIDTH-1:0]   occ_r;

    logic [DEPTH-1:0]       src_v_s;
    logic [DEPTH-1:0]       src_ow_s;
    logic [DATA_WIDTH-1:0]  src_data_s  [DEPTH];
    logic [COEFF_WIDTH-1:0] src_coeff_s [DEPTH];
    logic [DEPTH-1:0]       adv_s;
    logic                   clear_s;
    logic                   accept_s;
    logic                   emit_s;

    // Each stage loads from its upstream neighbour; stage 0 loads from the input port.
    for (genvar k = 0; k < DEPTH; k++) begin : g_src
        if (k == 0) begin : g_head
            assign src_v_s[k]     = in_valid;
            assign src_ow_s[k]    = overwrite_in;
            assign src_data_s[k]  = fir_input_in;
            assign src_coeff_s[k] = coeff_data_in;
        end else begin : g_body
            assign src_v_s[k]     = v_r[k-1];
            assign src_ow_s[k]    = ow_r[k-1];
            assign src_data_s[k]  = data_r[k-1];
            assign src_coeff_s[k] = coeff_r[k-1];
        end
    end

`ifdef FIR_PIPE_BUBBLE_COLLAPSE_EN
    logic chain_open_s;

    // Per-stage ready: a stage may load if out_ready is high or any stage at or beyond it is empty.
    always_comb begin
        adv_s        = '0;
        chain_open_s = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            chain_open_s = chain_open_s | ~v_r[k];
            adv_s[k]     = chain_open_s;
        end
    end
`else
    // Global stall: the whole chain freezes while the last stage is held by the consumer.
    always_comb begin
        adv_s = {DEPTH{~v_r[DEPTH-1] | out_ready}};
    end
`endif

    assign in_ready = adv_s[0];
    assign clear_s  = rst | flush;
    assign accept_s = in_valid & in_ready;
    assign emit_s   = v_r[DEPTH-1] & out_ready;

    // Stage registers and occupancy; clear wins over any advance, and payload only moves with a valid word.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            v_r   <= '0;
            ow_r  <= '0;
            occ_r <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_r[k]  <= '0;
                coeff_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (adv_s[k]) begin
                    v_r[k] <= src_v_s[k];
                    if (src_v_s[k]) begin
                        ow_r[k]    <= src_ow_s[k];
                        data_r[k]  <= src_data_s[k];
                        coeff_r[k] <= src_coeff_s[k];
                    end
                end
            end
            case ({accept_s, emit_s})
                2'b10:   occ_r <= occ_r + OCC_WIDTH'(1);
                2'b01:   occ_r <= occ_r - OCC_WIDTH'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign out_valid      = v_r[DEPTH-1];
    assign fir_input_out  = data_r[DEPTH-1];
    assign coeff_data_out = coeff_r[DEPTH-1];
    assign overwrite_out  = ow_r[DEPTH-1];
    assign occupancy      = occ_r;

endmodule

// File: tb/tb_fir_filter_gd_pipe_chain.sv
// Self-checking bench for fir_filter_gd_pipe_chain: directed plan steps plus random traffic vs a word-position model.
module tb_fir_filter_gd_pipe_chain;

    localparam int D  = 4;
    localparam int DW = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] fir_input_in = '0;
    logic [CW-1:0] coeff_data_in = '0;
    logic          overwrite_in = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] fir_input_out;
    logic [CW-1:0] coeff_data_out;
    logic          overwrite_out;
    logic [2:0]    occupancy;

    int checks = 0;
    int failures = 0;

    fir_filter_gd_pipe_chain #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .fir_input_in(fir_input_in), .coeff_data_in(coeff_data_in), .overwrite_in(overwrite_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .fir_input_out(fir_input_out), .coeff_data_out(coeff_data_out), .overwrite_out(overwrite_out),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Reference: words in flight in arrival order, each with the stage index it currently sits in.
    typedef struct {
        logic [31:0] d;
        logic [31:0] c;
        logic        o;
        int          pos;
    } ent_t;
    ent_t mq[$];

    function automatic bit m_out_valid();
        return (mq.size() > 0) && (mq[0].pos == D - 1);
    endfunction

    function automatic bit m_in_ready(input bit ordy);
`ifdef FIR_PIPE_BUBBLE_COLLAPSE_EN
        return (mq.size() < D) || ordy;
`else
        return !m_out_valid() || ordy;
`endif
    endfunction

    task automatic model_step(input bit acc, input bit ordy, input bit fl,
                              input logic [31:0] d, input logic [31:0] c, input bit o);
        bit   held;
        bit   emit;
        int   limit;
        ent_t e;
        if (fl) begin
            mq.delete();
            return;
        end
        held = m_out_valid() && !ordy;
        emit = m_out_valid() && ordy;
        if (emit) void'(mq.pop_front());
`ifdef FIR_PIPE_BUBBLE_COLLAPSE_EN
        limit = D;
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            if (e.pos + 1 < limit) e.pos = e.pos + 1;
            mq[i] = e;
            limit = e.pos;
        end
`else
        limit = D;
        if (!held) begin
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                e.pos = e.pos + 1;
                mq[i] = e;
            end
        end
`endif
        if (acc) begin
            e.d = d; e.c = c; e.o = o; e.pos = 0;
            mq.push_back(e);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare at the falling edge, advance the model, return just after the rising edge.
    task automatic step(input bit iv, input logic [31:0] d, input logic [31:0] c, input bit o,
                        input bit ordy, input bit fl);
        bit exp_rdy;
        bit exp_ov;
        in_valid = iv; fir_input_in = d; coeff_data_in = c; overwrite_in = o;
        out_ready = ordy; flush = fl;
        @(negedge clk);
        exp_rdy = m_in_ready(ordy);
        exp_ov  = m_out_valid();
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        chk("occupancy", {29'd0, occupancy}, mq.size());
        if (exp_ov) begin
            chk("fir_input_out", fir_input_out, mq[0].d);
            chk("coeff_data_out", coeff_data_out, mq[0].c);
            chk("overwrite_out", {31'd0, overwrite_out}, {31'd0, mq[0].o});
        end
        model_step(iv && exp_rdy, ordy, fl, d, c, o);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) begin
            if (mq.size() == 0) break;
            step(1'b0, $urandom, $urandom, 1'b0, 1'b1, 1'b0);
        end
        chk("drain_empty", {29'd0, occupancy}, 32'd0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; fir_input_in = 32'h0000_00AA;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        mq.delete();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_fir_out", fir_input_out, 32'd0);
        chk("rst_coeff_out", coeff_data_out, 32'd0);
        chk("rst_ow_out", {31'd0, overwrite_out}, 32'd0);
        chk("rst_occupancy", {29'd0, occupancy}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        // Reset held with in_valid asserted
        do_reset(3);

        // Streaming at full rate
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'h10 + i, $urandom, 1'($urandom), 1'b1, 1'b0);
            if (i == 2) chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
            if (i == 3) begin
                chk("lat_first_valid", {31'd0, out_valid}, 32'd1);
                chk("lat_first_data", fir_input_out, 32'h10);
            end
            if (i >= 3) chk("stream_occ", {29'd0, occupancy}, 32'd4);
        end
        drain();

        // Backpressure on a full chain
        for (int i = 0; i < 4; i++) step(1'b1, 32'h20 + i, $urandom, 1'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h99, $urandom, 1'b0, 1'b0, 1'b0);
            chk("bp_hold_data", fir_input_out, 32'h20);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        drain();

        // Bubbles under output stall
        step(1'b1, 32'h30, $urandom, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0,  $urandom, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h31, $urandom, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0,  $urandom, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h32 + i, $urandom, 1'b0, 1'b0, 1'b0);
`ifdef FIR_PIPE_BUBBLE_COLLAPSE_EN
            if (i == 0) chk("bubble_rdy_open", {31'd0, in_ready}, 32'd1);
`else
            if (i == 0) chk("bubble_rdy_shut", {31'd0, in_ready}, 32'd0);
`endif
        end
        chk("bubble_head", fir_input_out, 32'h30);
        chk("bubble_rdy_end", {31'd0, in_ready}, 32'd0);
`ifdef FIR_PIPE_BUBBLE_COLLAPSE_EN
        chk("bubble_occ", {29'd0, occupancy}, 32'd4);
`else
        chk("bubble_occ", {29'd0, occupancy}, 32'd2);
`endif
        drain();

        // Flush mid-stream at occupancy 3, with a word offered in the flush cycle
        for (int i = 0; i < 3; i++) step(1'b1, 32'h3A + i, $urandom, 1'b1, 1'b1, 1'b0);
        chk("pre_flush_occ", {29'd0, occupancy}, 32'd3);
        step(1'b1, 32'h40, 32'h4040_4040, 1'b1, 1'b1, 1'b1);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_fir_out", fir_input_out, 32'd0);
        chk("flush_coeff_out", coeff_data_out, 32'd0);
        chk("flush_ow_out", {31'd0, overwrite_out}, 32'd0);
        chk("flush_occ", {29'd0, occupancy}, 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Simultaneous accept and emit at full occupancy, overwrite pattern 1,0,1
        for (int i = 0; i < 4; i++) step(1'b1, 32'h50 + i, $urandom, 1'(i % 2 == 0), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h60 + i, $urandom, 1'(i != 1), 1'b1, 1'b0);
            chk("full_flow_occ", {29'd0, occupancy}, 32'd4);
        end
        drain();

        // Random traffic with occasional flush and one mid-run reset
        for (int i = 0; i < 300; i++) begin
            if (i == 150) do_reset(2);
            step(1'(($urandom % 4) != 0), $urandom, $urandom, 1'($urandom),
                 1'(($urandom % 3) != 0), 1'(($urandom % 50) == 0));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
